mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 23 ++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D-cache memory arbiter: reset/true levels,
// FSM state encoding (which doubles as the grant encoding) and beat limit.
package mem_arbiter_pkg;

   localparam logic RST_ENABLE = 1'b1;
   localparam logic TRUE_V     = 1'b1;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_I    = 2'b01;
   localparam logic [1:0] GNT_D    = 2'b10;

   localparam int unsigned BEATS_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE  = GNT_NONE,
      OWN_I = GNT_I,
      OWN_D = GNT_D
   } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Tie-break for the arbiter: a lone requester wins; on a tie the requester
// that was not granted last wins.
module mem_arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic       i_valid,
   input  logic       d_valid,
   input  arb_state_e last_gnt,
   output arb_state_e winner
);

   always_comb begin
      winner = IDLE;
      if (i_valid && d_valid) begin
         winner = (last_gnt == OWN_I) ? OWN_D : OWN_I;
      end else if (i_valid) begin
         winner = OWN_I;
      end else if (d_valid) begin
         winner = OWN_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter in front of a single RAM/AXI bridge.
// The owner's request is forwarded combinationally; grant tracks the FSM state.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned BEATS  = BEATS_DEFAULT
) (
   input  logic              cache_clk,
   input  logic              cache_rst,

   input  logic [3:0]        i_req,
   input  logic              i_wr,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   output logic              i_addr_ok,
   output logic              i_beat_ok,
   output logic              i_data_ok,
   output logic [31:0]       i_rdata,

   input  logic [3:0]        d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_addr_ok,
   output logic              d_beat_ok,
   output logic              d_data_ok,
   output logic [31:0]       d_rdata,

   output logic [3:0]        m_req,
   output logic              m_wr,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   input  logic              m_addr_ok,
   input  logic              m_beat_ok,
   input  logic              m_data_ok,
   input  logic [31:0]       m_rdata,

   output logic [1:0]        grant,
   output logic              arb_err
);

   arb_state_e state_q;
   arb_state_e last_gnt_q;
   arb_state_e pick_winner;
   logic       addr_seen_q;
   logic [4:0] beat_cnt_q;
   logic [4:0] beat_cnt_d;
   logic       arb_err_q;
   logic [3:0] own_req;

   mem_arb_pick u_pick (
      .i_valid  (i_req != 4'h0),
      .d_valid  (d_req != 4'h0),
      .last_gnt (last_gnt_q),
      .winner   (pick_winner)
   );

   always_comb begin
      own_req = (state_q == OWN_D) ? d_req : i_req;
      if (state_q == IDLE) begin
         beat_cnt_d = 5'd0;
      end else if (m_beat_ok && (beat_cnt_q != 5'd31)) begin
         beat_cnt_d = beat_cnt_q + 5'd1;
      end else begin
         beat_cnt_d = beat_cnt_q;
      end
   end

   always_ff @(posedge cache_clk) begin
      if (cache_rst == RST_ENABLE) begin
         state_q     <= IDLE;
         last_gnt_q  <= OWN_I;
         addr_seen_q <= 1'b0;
         beat_cnt_q  <= 5'd0;
         arb_err_q   <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         if (32'(beat_cnt_d) > BEATS) begin
            arb_err_q <= TRUE_V;
         end
         unique case (state_q)
            IDLE: begin
               addr_seen_q <= 1'b0;
               // The bridge must be silent while nobody owns it.
               if (m_data_ok || m_beat_ok) begin
                  arb_err_q <= TRUE_V;
               end
               state_q <= pick_winner;
            end
            OWN_I, OWN_D: begin
               if (m_data_ok) begin
                  state_q     <= IDLE;
                  last_gnt_q  <= state_q;
                  addr_seen_q <= 1'b0;
               end else if ((own_req == 4'h0) && !addr_seen_q && !m_addr_ok) begin
                  // Withdrawn before the bridge accepted it: not a completed grant.
                  state_q <= IDLE;
               end else if (m_addr_ok) begin
                  addr_seen_q <= TRUE_V;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      i_addr_ok = 1'b0;
      i_beat_ok = 1'b0;
      i_data_ok = 1'b0;
      i_rdata   = 32'h0;
      d_addr_ok = 1'b0;
      d_beat_ok = 1'b0;
      d_data_ok = 1'b0;
      d_rdata   = 32'h0;
      m_req     = 4'h0;
      m_wr      = 1'b0;
      m_addr    = '0;
      m_wdata   = 32'h0;
      grant     = GNT_NONE;
      arb_err   = 1'b0;
      if (cache_rst != RST_ENABLE) begin
         grant   = state_q;
         arb_err = arb_err_q;
         unique case (state_q)
            OWN_I: begin
               m_req     = i_req;
               m_wr      = i_wr;
               m_addr    = i_addr;
               m_wdata   = i_wdata;
               i_addr_ok = m_addr_ok;
               i_beat_ok = m_beat_ok;
               i_data_ok = m_data_ok;
               i_rdata   = m_rdata;
            end
            OWN_D: begin
               m_req     = d_req;
               m_wr      = d_wr;
               m_addr    = d_addr;
               m_wdata   = d_wdata;
               d_addr_ok = m_addr_ok;
               d_beat_ok = m_beat_ok;
               d_data_ok = m_data_ok;
               d_rdata   = m_rdata;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario and randomized bench for mem_arbiter against a cycle-level
// ownership model (owner / last winner / address accepted / beats / error).
module tb_mem_arbiter;

   localparam int BEATS = 16;

   logic        cache_clk = 1'b0;
   logic        cache_rst;
   logic [3:0]  i_req, d_req, m_req;
   logic        i_wr, d_wr, m_wr;
   logic [31:0] i_addr, d_addr, m_addr;
   logic [31:0] i_wdata, d_wdata, m_wdata;
   logic        i_addr_ok, i_beat_ok, i_data_ok;
   logic        d_addr_ok, d_beat_ok, d_data_ok;
   logic [31:0] i_rdata, d_rdata, m_rdata;
   logic        m_addr_ok, m_beat_ok, m_data_ok;
   logic [1:0]  grant;
   logic        arb_err;

   int vectors     = 0;
   int miscompares = 0;

   // Model: 0 none, 1 I-cache, 2 D-cache
   int mdl_owner = 0;
   int mdl_last  = 1;
   bit mdl_seen  = 0;
   int mdl_beats = 0;
   bit mdl_err   = 0;

   logic [141:0] act_bus;
   assign act_bus = {i_addr_ok, i_beat_ok, i_data_ok, i_rdata,
                     d_addr_ok, d_beat_ok, d_data_ok, d_rdata,
                     m_req, m_wr, m_addr, m_wdata, grant, arb_err};

   mem_arbiter #(.ADDR_W(32), .BEATS(BEATS)) dut (
      .cache_clk (cache_clk), .cache_rst (cache_rst),
      .i_req (i_req), .i_wr (i_wr), .i_addr (i_addr), .i_wdata (i_wdata),
      .i_addr_ok (i_addr_ok), .i_beat_ok (i_beat_ok), .i_data_ok (i_data_ok),
      .i_rdata (i_rdata),
      .d_req (d_req), .d_wr (d_wr), .d_addr (d_addr), .d_wdata (d_wdata),
      .d_addr_ok (d_addr_ok), .d_beat_ok (d_beat_ok), .d_data_ok (d_data_ok),
      .d_rdata (d_rdata),
      .m_req (m_req), .m_wr (m_wr), .m_addr (m_addr), .m_wdata (m_wdata),
      .m_addr_ok (m_addr_ok), .m_beat_ok (m_beat_ok), .m_data_ok (m_data_ok),
      .m_rdata (m_rdata),
      .grant (grant), .arb_err (arb_err)
   );

   always #5 cache_clk = ~cache_clk;

   function automatic void model_step();
      int x_req;
      if (cache_rst) begin
         mdl_owner = 0; mdl_last = 1; mdl_seen = 0; mdl_beats = 0; mdl_err = 0;
         return;
      end
      if (mdl_owner == 0) begin
         if (m_data_ok || m_beat_ok) mdl_err = 1;
         mdl_beats = 0;
         mdl_seen  = 0;
         if (i_req != 0 && d_req != 0) mdl_owner = (mdl_last == 1) ? 2 : 1;
         else if (i_req != 0)          mdl_owner = 1;
         else if (d_req != 0)          mdl_owner = 2;
      end else begin
         x_req = (mdl_owner == 1) ? int'(i_req) : int'(d_req);
         if (m_beat_ok && mdl_beats < 31) mdl_beats++;
         if (mdl_beats > BEATS) mdl_err = 1;
         if (m_data_ok) begin
            mdl_last  = mdl_owner;
            mdl_owner = 0;
            mdl_beats = 0;
            mdl_seen  = 0;
         end else if (x_req == 0 && !mdl_seen && !m_addr_ok) begin
            mdl_owner = 0;
         end else if (m_addr_ok) begin
            mdl_seen = 1;
         end
      end
   endfunction

   function automatic logic [141:0] expected_bus();
      logic [34:0] iside, dside;
      logic [3:0]  mr;
      logic        mw;
      logic [31:0] ma, md;
      iside = '0; dside = '0; mr = '0; mw = 1'b0; ma = '0; md = '0;
      if (cache_rst) return '0;
      if (mdl_owner == 1) begin
         mr = i_req; mw = i_wr; ma = i_addr; md = i_wdata;
         iside = {m_addr_ok, m_beat_ok, m_data_ok, m_rdata};
      end else if (mdl_owner == 2) begin
         mr = d_req; mw = d_wr; ma = d_addr; md = d_wdata;
         dside = {m_addr_ok, m_beat_ok, m_data_ok, m_rdata};
      end
      return {iside, dside, mr, mw, ma, md, 2'(mdl_owner), mdl_err};
   endfunction

   task automatic tick();
      @(posedge cache_clk);
      model_step();
      #1;
   endtask

   task automatic clear_inputs();
      i_req = 4'h0; i_wr = 1'b0; i_addr = 32'h0; i_wdata = 32'h0;
      d_req = 4'h0; d_wr = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      m_addr_ok = 1'b0; m_beat_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;
   endtask

   task automatic do_reset();
      cache_rst = 1'b1;
      clear_inputs();
      tick();
      cache_rst = 1'b0;
   endtask

   task automatic test_reset();
      cache_rst = 1'b1;
      i_req = 4'hF; d_req = 4'hF; i_addr = 32'hDEAD_BEEF;
      m_beat_ok = 1'b1; m_data_ok = 1'b1; m_addr_ok = 1'b1; m_rdata = 32'h1234_5678;
      #1;
      vectors++;
      if (act_bus !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h want 0", act_bus);
      end
      tick();
      cache_rst = 1'b0;
      clear_inputs();
      #1;
      vectors++;
      if (grant !== 2'b00 || arb_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: grant %b err %b want 00 0", grant, arb_err);
      end
   endtask

   task automatic test_single_read();
      int beats_seen = 0;
      logic [31:0] rd;
      do_reset();
      i_req = 4'hF; i_wr = 1'b0; i_addr = 32'h0000_1000;
      #1;
      vectors++;
      if (grant !== 2'b00 || m_req !== 4'h0) begin
         miscompares++;
         $display("FAIL read_idle: grant %b m_req %h want 00 0", grant, m_req);
      end
      tick();
      vectors++;
      if (grant !== 2'b01 || m_req !== 4'hF || m_addr !== 32'h0000_1000) begin
         miscompares++;
         $display("FAIL read_grant: grant %b m_req %h m_addr %h want 01 f 00001000",
                  grant, m_req, m_addr);
      end
      m_addr_ok = 1'b1;
      #1;
      vectors++;
      if (i_addr_ok !== 1'b1 || d_addr_ok !== 1'b0) begin
         miscompares++;
         $display("FAIL read_addr_ok: i %b d %b want 1 0", i_addr_ok, d_addr_ok);
      end
      tick();
      m_addr_ok = 1'b0;
      i_req = 4'h0;  // ownership must survive after address acceptance
      for (int k = 0; k < 16; k++) begin
         rd = $urandom;
         m_beat_ok = 1'b1; m_rdata = rd;
         #1;
         if (i_beat_ok === 1'b1 && i_rdata === rd && d_beat_ok === 1'b0) beats_seen++;
         tick();
      end
      m_beat_ok = 1'b0;
      vectors++;
      if (beats_seen != 16 || grant !== 2'b01) begin
         miscompares++;
         $display("FAIL read_beats: beats %0d grant %b want 16 01", beats_seen, grant);
      end
      m_data_ok = 1'b1;
      #1;
      vectors++;
      if (i_data_ok !== 1'b1) begin
         miscompares++;
         $display("FAIL read_data_ok: got %b want 1", i_data_ok);
      end
      tick();
      m_data_ok = 1'b0;
      #1;
      vectors++;
      if (grant !== 2'b00 || i_data_ok !== 1'b0 || arb_err !== 1'b0) begin
         miscompares++;
         $display("FAIL read_done: grant %b data_ok %b err %b want 00 0 0",
                  grant, i_data_ok, arb_err);
      end
   endtask

   task automatic test_tie();
      do_reset();
      i_req = 4'hF; i_addr = 32'h0000_3000;
      d_req = 4'hF; d_addr = 32'h0000_4000;
      tick();
      vectors++;
      if (grant !== 2'b10) begin
         miscompares++;
         $display("FAIL tie_first: got %b want 10", grant);
      end
      m_addr_ok = 1'b1;
      tick();
      m_addr_ok = 1'b0; m_data_ok = 1'b1;
      #1;
      vectors++;
      if (d_data_ok !== 1'b1 || i_data_ok !== 1'b0) begin
         miscompares++;
         $display("FAIL tie_d_done: d %b i %b want 1 0", d_data_ok, i_data_ok);
      end
      tick();
      m_data_ok = 1'b0;
      #1;
      vectors++;
      if (grant !== 2'b00) begin
         miscompares++;
         $display("FAIL tie_gap: got %b want 00", grant);
      end
      tick();
      vectors++;
      if (grant !== 2'b01 || m_addr !== 32'h0000_3000) begin
         miscompares++;
         $display("FAIL tie_second: grant %b addr %h want 01 00003000", grant, m_addr);
      end
      m_data_ok = 1'b1;
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_contention();
      logic [31:0] wd;
      wd = $urandom;
      do_reset();
      i_req = 4'hF; i_addr = 32'h0000_2000;
      tick();
      m_addr_ok = 1'b1;
      tick();
      m_addr_ok = 1'b0;
      m_beat_ok = 1'b1;
      for (int k = 0; k < 7; k++) tick();
      m_beat_ok = 1'b0;
      d_req = 4'h3; d_wr = 1'b1; d_addr = 32'h8000_0040; d_wdata = wd;
      m_addr_ok = 1'b1;
      #1;
      vectors++;
      if (d_addr_ok !== 1'b0 || m_addr !== 32'h0000_2000 || m_req !== 4'hF) begin
         miscompares++;
         $display("FAIL contend_mid: d_addr_ok %b m_addr %h m_req %h want 0 00002000 f",
                  d_addr_ok, m_addr, m_req);
      end
      tick();
      m_addr_ok = 1'b0;
      m_beat_ok = 1'b1;
      for (int k = 0; k < 9; k++) tick();
      m_beat_ok = 1'b0;
      m_data_ok = 1'b1; i_req = 4'h0;
      #1;
      vectors++;
      if (d_addr_ok !== 1'b0 || d_data_ok !== 1'b0 || m_req !== 4'h0) begin
         miscompares++;
         $display("FAIL contend_end: d_addr_ok %b d_data_ok %b m_req %h want 0 0 0",
                  d_addr_ok, d_data_ok, m_req);
      end
      tick();
      m_data_ok = 1'b0;
      #1;
      vectors++;
      if (grant !== 2'b00 || m_req !== 4'h0 || m_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL contend_idle: grant %b m_req %h m_addr %h want 00 0 0",
                  grant, m_req, m_addr);
      end
      tick();
      m_addr_ok = 1'b1;
      #1;
      vectors++;
      if (grant !== 2'b10 || m_req !== 4'h3 || m_addr !== 32'h8000_0040 ||
          m_wr !== 1'b1 || m_wdata !== wd || d_addr_ok !== 1'b1) begin
         miscompares++;
         $display("FAIL contend_d: grant %b m_req %h m_addr %h wr %b wdata %h aok %b",
                  grant, m_req, m_addr, m_wr, m_wdata, d_addr_ok);
      end
      tick();
      m_addr_ok = 1'b0; m_data_ok = 1'b1; d_req = 4'h0;
      tick();
      clear_inputs();
      #1;
      vectors++;
      if (arb_err !== 1'b0 || grant !== 2'b00) begin
         miscompares++;
         $display("FAIL contend_clean: err %b grant %b want 0 00", arb_err, grant);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      d_req = 4'hF; d_addr = 32'h0000_5000;
      tick();
      m_addr_ok = 1'b1;
      tick();
      m_addr_ok = 1'b0;
      m_beat_ok = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      m_rdata = 32'hCAFE_F00D; m_data_ok = 1'b1; m_addr_ok = 1'b1;
      cache_rst = 1'b1;
      #1;
      vectors++;
      if (act_bus !== '0) begin
         miscompares++;
         $display("FAIL rstmid_comb: got %h want 0", act_bus);
      end
      tick();
      vectors++;
      if (act_bus !== '0) begin
         miscompares++;
         $display("FAIL rstmid_held: got %h want 0", act_bus);
      end
      cache_rst = 1'b0;
      clear_inputs();
      #1;
      vectors++;
      if (grant !== 2'b00 || arb_err !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_after: grant %b err %b want 00 0", grant, arb_err);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      i_req = 4'hF; i_addr = 32'h0000_6000;
      tick();
      m_addr_ok = 1'b1;
      tick();
      m_addr_ok = 1'b0;
      m_beat_ok = 1'b1;
      for (int k = 0; k < 17; k++) begin
         if (k == 16) begin
            vectors++;
            if (arb_err !== 1'b0) begin
               miscompares++;
               $display("FAIL ovf_at_limit: got %b want 0", arb_err);
            end
         end
         tick();
      end
      m_beat_ok = 1'b0;
      #1;
      vectors++;
      if (arb_err !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_set: got %b want 1", arb_err);
      end
      m_data_ok = 1'b1; i_req = 4'h0;
      tick();
      clear_inputs();
      for (int k = 0; k < 4; k++) tick();
      vectors++;
      if (arb_err !== 1'b1 || grant !== 2'b00) begin
         miscompares++;
         $display("FAIL ovf_sticky: err %b grant %b want 1 00", arb_err, grant);
      end
      do_reset();
      #1;
      vectors++;
      if (arb_err !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_cleared: got %b want 0", arb_err);
      end
   endtask

   task automatic test_withdraw();
      do_reset();
      d_req = 4'h3; d_addr = 32'h0000_7000;
      tick();
      vectors++;
      if (grant !== 2'b10) begin
         miscompares++;
         $display("FAIL wd_grant: got %b want 10", grant);
      end
      d_req = 4'h0;
      tick();
      vectors++;
      if (grant !== 2'b00) begin
         miscompares++;
         $display("FAIL wd_release: got %b want 00", grant);
      end
      i_req = 4'hF; d_req = 4'hF;
      tick();
      vectors++;
      if (grant !== 2'b10) begin
         miscompares++;
         $display("FAIL wd_tie: got %b want 10", grant);
      end
      m_data_ok = 1'b1;
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_random();
      logic [141:0] exp_bus;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         cache_rst = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 7) == 0) begin
            i_req = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            i_wr = 1'($urandom); i_addr = $urandom; i_wdata = $urandom;
         end
         if ($urandom_range(0, 7) == 0) begin
            d_req = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            d_wr = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
         end
         m_addr_ok = ($urandom_range(0, 3) == 0);
         m_beat_ok = ($urandom_range(0, 1) == 0);
         m_data_ok = ($urandom_range(0, 15) == 0);
         m_rdata   = $urandom;
         #1;
         exp_bus = expected_bus();
         vectors++;
         if (act_bus !== exp_bus) begin
            miscompares++;
            $display("FAIL random_cycle%0d: got %h want %h", n, act_bus, exp_bus);
         end
         tick();
      end
      cache_rst = 1'b0;
      clear_inputs();
   endtask

   initial begin
      cache_rst = 1'b1;
      clear_inputs();
      test_reset();
      test_single_read();
      test_tie();
      test_contention();
      test_reset_mid();
      test_overflow();
      test_withdraw();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
